// File: rtl/pipeline_credit_fifo_v1_0.sv
// pipeline_credit_fifo_v1_0
// Credit-managed first-word-fall-through buffer placed after a fixed-latency
// delay pipeline. It hands out credits to the producer feeding the pipeline,
// tracks words in flight through it and captures the pipeline output, so a
// stalling consumer never loses a word.
//
// Optional feature macro: PIPELINE_CREDIT_FIFO_OVF_CHK_EN
//   defined   : OVF is a sticky flag set by a dropped write or by an issue
//               while IN_READY=0; simulation prints a message per event.
//   undefined : OVF is tied to 0.
//
// Ports:
//   CLK      in   rising-edge clock
//   ACLR     in   asynchronous clear, active-high (also zeroes the memory)
//   SCLR     in   synchronous clear, active-high (memory kept)
//   IN_VALID in   producer issues a word into the upstream pipeline
//   IN_READY out  credit available (combinational from registered state)
//   D        in   upstream pipeline output data
//   D_VALID  in   delayed issue strobe aligned with D
//   Q        out  FIFO head data (fall-through)
//   Q_VALID  out  FIFO non-empty
//   Q_READY  in   consumer accepts the head word
//   COUNT    out  FIFO occupancy
//   OVF      out  sticky overflow flag

module pipeline_credit_fifo_v1_0 #(
   parameter int unsigned C_WIDTH       = 16,
   parameter int unsigned C_DEPTH       = 4,
   parameter int unsigned C_PIPE_STAGES = 1
) (
   input  logic                           CLK,
   input  logic                           ACLR,
   input  logic                           SCLR,
   input  logic                           IN_VALID,
   output logic                           IN_READY,
   input  logic [C_WIDTH-1:0]             D,
   input  logic                           D_VALID,
   output logic [C_WIDTH-1:0]             Q,
   output logic                           Q_VALID,
   input  logic                           Q_READY,
   output logic [$clog2(C_DEPTH+1)-1:0]   COUNT,
   output logic                           OVF
);

   localparam int unsigned AW = $clog2(C_DEPTH);
   localparam int unsigned CW = $clog2(C_DEPTH + 1);
   // One extra bit so COUNT + inflight cannot wrap in the credit compare.
   localparam int unsigned SW = CW + 1;

   // Elaboration-time parameter sanity.
   if (C_DEPTH < 2 || (C_DEPTH & (C_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("C_DEPTH must be a power of two and at least 2");
   end
   if (C_PIPE_STAGES == 0) begin : g_bad_pipe
      $error("C_PIPE_STAGES must be at least 1");
   end

   logic [C_WIDTH-1:0] mem [C_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [CW-1:0]      inflight;

   logic issue_c;
   logic wr_en_c;
   logic rd_en_c;

   // Handshake decodes.
   assign issue_c = IN_VALID & IN_READY;
   assign wr_en_c = D_VALID & (count < CW'(C_DEPTH));
   assign rd_en_c = Q_READY & (count != '0);

   // Credit from registered state only: a read frees its slot next cycle.
   assign IN_READY = (SW'(count) + SW'(inflight)) < SW'(C_DEPTH);

   // Fall-through head.
   assign Q       = mem[rd_ptr];
   assign Q_VALID = (count != '0);
   assign COUNT   = count;

   // Pointers, occupancy and in-flight tracking.
   always_ff @(posedge CLK or posedge ACLR) begin : p_ctrl
      if (ACLR) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
      end else if (SCLR) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en_c) rd_ptr <= rd_ptr + AW'(1);

         case ({wr_en_c, rd_en_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase

         // Saturates at 0 so words surviving an SCLR land without underflow.
         case ({issue_c, D_VALID})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   if (inflight != '0) inflight <= inflight - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage; SCLR blocks the write but keeps existing contents.
   always_ff @(posedge CLK or posedge ACLR) begin : p_mem
      if (ACLR) begin
         mem <= '{default: '0};
      end else if (!SCLR && wr_en_c) begin
         mem[wr_ptr] <= D;
      end
   end

`ifdef PIPELINE_CREDIT_FIFO_OVF_CHK_EN
   logic ovf;
   logic drop_c;
   logic bad_issue_c;

   assign drop_c      = D_VALID & (count == CW'(C_DEPTH));
   assign bad_issue_c = IN_VALID & ~IN_READY;

   // Sticky until a clear.
   always_ff @(posedge CLK or posedge ACLR) begin : p_ovf
      if (ACLR) begin
         ovf <= 1'b0;
      end else if (SCLR) begin
         ovf <= 1'b0;
      end else if (drop_c || bad_issue_c) begin
         ovf <= 1'b1;
      end
   end

   assign OVF = ovf;

`ifndef SYNTHESIS
   // Event messages for simulation only.
   always @(posedge CLK) begin
      if (!ACLR && !SCLR) begin
         if (drop_c)
            $display("%m: %0t: write dropped, FIFO full (pipe stages %0d)", $time, C_PIPE_STAGES);
         if (bad_issue_c)
            $display("%m: %0t: issue without credit", $time);
      end
   end
`endif
`else
   assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_credit_fifo_v1_0.sv
// Directed bench for pipeline_credit_fifo_v1_0 with C_DEPTH=4 and a 2-stage
// upstream pipeline modelled in the bench.
module tb_pipeline_credit_fifo_v1_0;

   localparam int unsigned W = 16;

`ifdef PIPELINE_CREDIT_FIFO_OVF_CHK_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic          CLK      = 1'b0;
   logic          ACLR     = 1'b1;
   logic          SCLR     = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [W-1:0]  D;
   logic          D_VALID;
   logic [W-1:0]  Q;
   logic          Q_VALID;
   logic          Q_READY  = 1'b0;
   logic [2:0]    COUNT;
   logic          OVF;

   // Upstream pipeline model plus a direct-drive path for forced arrivals.
   logic [W-1:0]  in_data = '0;
   logic          f_dv    = 1'b0;
   logic [W-1:0]  f_d     = '0;
   logic          pv1 = 1'b0, pv2 = 1'b0;
   logic [W-1:0]  pd1 = '0, pd2 = '0;
   int unsigned   issued = 0;

   int unsigned   n_checks = 0;
   int unsigned   n_pass   = 0;
   int unsigned   n_fail   = 0;

   pipeline_credit_fifo_v1_0 #(
      .C_WIDTH       (W),
      .C_DEPTH       (4),
      .C_PIPE_STAGES (2)
   ) dut (
      .CLK      (CLK),
      .ACLR     (ACLR),
      .SCLR     (SCLR),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .D        (D),
      .D_VALID  (D_VALID),
      .Q        (Q),
      .Q_VALID  (Q_VALID),
      .Q_READY  (Q_READY),
      .COUNT    (COUNT),
      .OVF      (OVF)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      pv1 <= IN_VALID & IN_READY;
      pd1 <= in_data;
      pv2 <= pv1;
      pd2 <= pd1;
      if (IN_VALID & IN_READY) issued <= issued + 1;
   end

   assign D_VALID = pv2 | f_dv;
   assign D       = f_dv ? f_d : pd2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   initial begin
      int unsigned base;
      int unsigned exp_q;
      logic [W-1:0] drain [4];

      // Reset held across clock edges.
      tick(); tick();
      check("rst_count",    32'(COUNT),    32'd0);
      check("rst_qvalid",   32'(Q_VALID),  32'd0);
      check("rst_q",        32'(Q),        32'd0);
      check("rst_in_ready", 32'(IN_READY), 32'd1);
      check("rst_ovf",      32'(OVF),      32'd0);
      ACLR = 1'b0;
      tick();

      // Ordering and wrap: ten words, consumer ready toggling.
      base  = issued;
      exp_q = 1;
      for (int cyc = 0; cyc < 120 && exp_q <= 10; cyc++) begin
         Q_READY  = ~Q_READY;
         IN_VALID = ((issued - base) < 10) && IN_READY;
         in_data  = W'(issued - base + 1);
         if (Q_VALID && Q_READY) begin
            check("order_q", 32'(Q), exp_q);
            exp_q++;
         end
         tick();
      end
      IN_VALID = 1'b0;
      Q_READY  = 1'b0;
      check("order_all_read", exp_q, 32'd11);
      check("order_issued",   issued - base, 32'd10);
      check("order_empty",    32'(COUNT), 32'd0);
      check("order_ovf",      32'(OVF),   32'd0);

      // Fill and block: issue whenever credit exists, consumer stalled.
      base = issued;
      for (int k = 0; k < 4; k++) begin
         IN_VALID = IN_READY;
         in_data  = 16'h0100 + W'(issued - base);
         tick();
      end
      check("fill_issued_e4",   issued - base, 32'd4);
      check("fill_ready_e4",    32'(IN_READY), 32'd0);
      check("fill_count_e4",    32'(COUNT),    32'd2);
      for (int k = 0; k < 2; k++) begin
         IN_VALID = IN_READY;
         in_data  = 16'h0100 + W'(issued - base);
         tick();
      end
      check("fill_count_e6",    32'(COUNT), 32'd4);
      check("fill_ovf",         32'(OVF),   32'd0);
      for (int k = 0; k < 2; k++) begin
         IN_VALID = IN_READY;
         tick();
      end
      IN_VALID = 1'b0;
      check("fill_issued_end",  issued - base, 32'd4);
      check("fill_ready_end",   32'(IN_READY), 32'd0);
      check("fill_head",        32'(Q),        32'h0100);

      // SCLR keeps memory: rd_ptr returns to entry 0, which holds 0x0102.
      SCLR = 1'b1;
      tick();
      SCLR = 1'b0;
      check("sclr_count",    32'(COUNT),    32'd0);
      check("sclr_qvalid",   32'(Q_VALID),  32'd0);
      check("sclr_ready",    32'(IN_READY), 32'd1);
      check("sclr_mem_kept", 32'(Q),        32'h0102);

      // Read on empty is ignored.
      Q_READY = 1'b1;
      tick();
      Q_READY = 1'b0;
      check("empty_read_count", 32'(COUNT), 32'd0);

      // Simultaneous read and write at COUNT=2.
      f_dv = 1'b1; f_d = 16'h00A1; tick();
      f_d  = 16'h00A2;             tick();
      f_dv = 1'b0;
      check("rw_pre_count", 32'(COUNT), 32'd2);
      check("rw_pre_head",  32'(Q),     32'h00A1);
      f_dv = 1'b1; f_d = 16'h00A3; Q_READY = 1'b1;
      tick();
      f_dv = 1'b0; Q_READY = 1'b0;
      check("rw_count", 32'(COUNT),    32'd2);
      check("rw_head",  32'(Q),        32'h00A2);
      check("rw_ready", 32'(IN_READY), 32'd1);
      f_dv = 1'b1; f_d = 16'h00A4; tick();
      f_dv = 1'b0;
      check("sat_count",    32'(COUNT),        32'd3);
      check("sat_inflight", 32'(dut.inflight), 32'd0);
      check("sat_ready",    32'(IN_READY),     32'd1);

      // Asynchronous clear mid-stream, observed before any clock edge.
      #2 ACLR = 1'b1;
      #1;
      check("aclr_count",  32'(COUNT),    32'd0);
      check("aclr_qvalid", 32'(Q_VALID),  32'd0);
      check("aclr_q",      32'(Q),        32'd0);
      check("aclr_ready",  32'(IN_READY), 32'd1);
      check("aclr_ovf",    32'(OVF),      32'd0);
      tick();
      ACLR = 1'b0;
      tick();

      // SCLR while two words are in the pipeline.
      IN_VALID = 1'b1; in_data = 16'h00B1; tick();
      in_data  = 16'h00B2; SCLR = 1'b1;     tick();
      IN_VALID = 1'b0; SCLR = 1'b0;
      check("sclrpipe_count0",    32'(COUNT),        32'd0);
      check("sclrpipe_inflight0", 32'(dut.inflight), 32'd0);
      tick();
      check("sclrpipe_count1",    32'(COUNT),        32'd1);
      tick();
      check("sclrpipe_count2",    32'(COUNT),        32'd2);
      check("sclrpipe_inflight2", 32'(dut.inflight), 32'd0);
      check("sclrpipe_head",      32'(Q),            32'h00B1);

      // Overflow: fill to 4 then force one more arrival.
      f_dv = 1'b1; f_d = 16'h00C3; tick();
      f_d  = 16'h00C4;             tick();
      f_dv = 1'b0;
      check("ovf_full_count", 32'(COUNT),    32'd4);
      check("ovf_full_ready", 32'(IN_READY), 32'd0);
      f_dv = 1'b1; f_d = 16'h00C5; tick();
      f_dv = 1'b0;
      check("ovf_drop_count", 32'(COUNT), 32'd4);
      check("ovf_drop_head",  32'(Q),     32'h00B1);
      check("ovf_flag",       32'(OVF),   32'(OVF_EXP));
      tick();
      check("ovf_held",       32'(OVF),   32'(OVF_EXP));
      drain[0] = 16'h00B1; drain[1] = 16'h00B2; drain[2] = 16'h00C3; drain[3] = 16'h00C4;
      Q_READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("ovf_drain_q", 32'(Q), 32'(drain[k]));
         tick();
      end
      Q_READY = 1'b0;
      check("ovf_drain_empty", 32'(COUNT), 32'd0);
      check("ovf_still_held",  32'(OVF),   32'(OVF_EXP));
      SCLR = 1'b1; tick(); SCLR = 1'b0;
      check("ovf_sclr", 32'(OVF), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time bound.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
